// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS receive channel: word alignment search and 10b/8b decode
//
// Ports:
//   pixclk      : clock, all logic on rising edge
//   rst         : synchronous active-high reset
//   tmds_in     : 10-bit deserialized word, bit 0 transmitted first
//   data_out    : decoded pixel byte (valid when de_out=1)
//   ctrl_out    : decoded control value {c1,c0}
//   de_out      : data enable
//   locked      : word alignment achieved
//   bitslip     : one-cycle request to shift deserializer alignment by one bit
//   slip_count  : saturating count of bitslip pulses (TMDS_STATS_EN only)
//   loss_count  : saturating count of lock losses (TMDS_STATS_EN only)
//
// Optional feature macro: TMDS_STATS_EN
module tmds_channel_decoder #(
    parameter int MIN_RUN       = 8,
    parameter int SEARCH_WINDOW = 4096,
    parameter int SLIP_SETTLE   = 16,
    parameter int LOSS_WINDOW   = 4096
) (
    input  logic        pixclk,
    input  logic        rst,
    input  logic [9:0]  tmds_in,
    output logic [7:0]  data_out,
    output logic [1:0]  ctrl_out,
    output logic        de_out,
    output logic        locked,
`ifdef TMDS_STATS_EN
    output logic        bitslip,
    output logic [15:0] slip_count,
    output logic [15:0] loss_count
`else
    output logic        bitslip
`endif
);

    localparam logic [15:0] MIN_RUN_C = 16'(MIN_RUN);
    localparam logic [15:0] SW_LAST   = 16'(SEARCH_WINDOW - 1);
    localparam logic [15:0] SS_LAST   = 16'(SLIP_SETTLE - 1);
    localparam logic [15:0] LW_LAST   = 16'(LOSS_WINDOW - 1);

    typedef enum logic [1:0] {HUNT, SETTLE, LOCKED} state_t;

    state_t      state, state_nxt;
    logic [15:0] run_cnt, run_nxt;
    logic [15:0] win_cnt, win_nxt;
    // Shared counter: settle cycles in SETTLE, token-free cycles in LOCKED.
    logic [15:0] aux_cnt, aux_nxt;
    logic [15:0] run_inc, loss_inc;
    logic        slip_nxt;

    logic        is_tok;
    logic [1:0]  tok_val;
    logic [7:0]  d_inv;
    logic [7:0]  dec;

    always_comb begin
        is_tok  = 1'b1;
        tok_val = 2'b00;
        case (tmds_in)
            10'h354: tok_val = 2'b00;
            10'h0AB: tok_val = 2'b01;
            10'h154: tok_val = 2'b10;
            10'h2AB: tok_val = 2'b11;
            default: is_tok  = 1'b0;
        endcase
    end

    always_comb begin
        d_inv  = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0];
        dec    = 8'h00;
        dec[0] = d_inv[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = tmds_in[8] ? (d_inv[i] ^ d_inv[i-1]) : ~(d_inv[i] ^ d_inv[i-1]);
        end
    end

    always_comb begin
        state_nxt = state;
        run_nxt   = run_cnt;
        win_nxt   = win_cnt;
        aux_nxt   = aux_cnt;
        slip_nxt  = 1'b0;
        run_inc   = is_tok ? run_cnt + 16'd1 : 16'd0;
        loss_inc  = is_tok ? 16'd0 : aux_cnt + 16'd1;
        case (state)
            HUNT: begin
                run_nxt = run_inc;
                win_nxt = win_cnt + 16'd1;
                // Lock takes priority over a slip falling on the same cycle.
                if (run_inc == MIN_RUN_C) begin
                    state_nxt = LOCKED;
                    run_nxt   = 16'd0;
                    win_nxt   = 16'd0;
                    aux_nxt   = 16'd0;
                end else if (win_cnt == SW_LAST) begin
                    state_nxt = SETTLE;
                    slip_nxt  = 1'b1;
                    run_nxt   = 16'd0;
                    win_nxt   = 16'd0;
                    aux_nxt   = 16'd0;
                end
            end
            SETTLE: begin
                if (aux_cnt == SS_LAST) begin
                    state_nxt = HUNT;
                    aux_nxt   = 16'd0;
                end else begin
                    aux_nxt = aux_cnt + 16'd1;
                end
            end
            LOCKED: begin
                if (loss_inc == LW_LAST) begin
                    state_nxt = HUNT;
                    run_nxt   = 16'd0;
                    win_nxt   = 16'd0;
                    aux_nxt   = 16'd0;
                end else begin
                    aux_nxt = loss_inc;
                end
            end
            default: begin
                state_nxt = HUNT;
                run_nxt   = 16'd0;
                win_nxt   = 16'd0;
                aux_nxt   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            state   <= HUNT;
            run_cnt <= 16'd0;
            win_cnt <= 16'd0;
            aux_cnt <= 16'd0;
            bitslip <= 1'b0;
            locked  <= 1'b0;
        end else begin
            state   <= state_nxt;
            run_cnt <= run_nxt;
            win_cnt <= win_nxt;
            aux_cnt <= aux_nxt;
            bitslip <= slip_nxt;
            locked  <= (state_nxt == LOCKED);
        end
    end

    // Outputs follow the next state so the locking token is presented on the
    // same edge that raises locked, and the lock-loss edge zeroes them.
    always_ff @(posedge pixclk) begin
        if (rst) begin
            data_out <= 8'h00;
            ctrl_out <= 2'b00;
            de_out   <= 1'b0;
        end else if (state_nxt == LOCKED) begin
            if (is_tok) begin
                data_out <= 8'h00;
                ctrl_out <= tok_val;
                de_out   <= 1'b0;
            end else begin
                data_out <= dec;
                de_out   <= 1'b1;
            end
        end else begin
            data_out <= 8'h00;
            ctrl_out <= 2'b00;
            de_out   <= 1'b0;
        end
    end

`ifdef TMDS_STATS_EN
    always_ff @(posedge pixclk) begin
        if (rst) begin
            slip_count <= 16'd0;
            loss_count <= 16'd0;
        end else begin
            if (slip_nxt && slip_count != 16'hFFFF) begin
                slip_count <= slip_count + 16'd1;
            end
            if (state == LOCKED && state_nxt == HUNT && loss_count != 16'hFFFF) begin
                loss_count <= loss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - directed self-checking bench for tmds_channel_decoder
module tb_tmds_channel_decoder;

    logic        pixclk = 1'b0;
    logic        rst    = 1'b1;
    logic [9:0]  tmds_in = 10'h000;
    logic [7:0]  data_out;
    logic [1:0]  ctrl_out;
    logic        de_out;
    logic        locked;
    logic        bitslip;
`ifdef TMDS_STATS_EN
    logic [15:0] slip_count;
    logic [15:0] loss_count;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 pixclk = ~pixclk;

    tmds_channel_decoder dut (
        .pixclk   (pixclk),
        .rst      (rst),
        .tmds_in  (tmds_in),
        .data_out (data_out),
        .ctrl_out (ctrl_out),
        .de_out   (de_out),
        .locked   (locked),
`ifdef TMDS_STATS_EN
        .bitslip    (bitslip),
        .slip_count (slip_count),
        .loss_count (loss_count)
`else
        .bitslip  (bitslip)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one word, let one rising edge sample it, settle after the edge.
    task automatic step(input logic [9:0] w);
        tmds_in = w;
        @(posedge pixclk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] d, input logic [1:0] c,
                              input logic de, input logic lk);
        check({tag, "_data"},   32'(data_out), 32'(d));
        check({tag, "_ctrl"},   32'(ctrl_out), 32'(c));
        check({tag, "_de"},     32'(de_out),   32'(de));
        check({tag, "_locked"}, 32'(locked),   32'(lk));
    endtask

    int first_slip;
    int second_slip;
    int n_slips;
    int lock_seen;
    int slip_seen;

    initial begin
        // Reset with tokens on the input: nothing may lock or slip.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(10'h354);
            check_outs("reset", 8'h00, 2'b00, 1'b0, 1'b0);
            check("reset_bitslip", 32'(bitslip), 32'd0);
        end
        rst = 1'b0;

        // Seven tokens then a data word: no lock.
        for (int i = 1; i <= 7; i++) begin
            step(10'h354);
            check("pre7_locked", 32'(locked), 32'd0);
            if (i == 1) check("post_release_bitslip", 32'(bitslip), 32'd0);
        end
        step(10'h100);
        check_outs("seven_then_data", 8'h00, 2'b00, 1'b0, 1'b0);

        // Eight tokens: lock on the 8th, token presented as control.
        for (int i = 1; i <= 8; i++) begin
            step(10'h354);
            if (i == 7) check("run7_locked", 32'(locked), 32'd0);
        end
        check_outs("lock", 8'h00, 2'b00, 1'b0, 1'b1);

        // Decode while locked.
        step(10'h0FF); check_outs("dec_0ff", 8'hFF, 2'b00, 1'b1, 1'b1);
        step(10'h100); check_outs("dec_100", 8'h00, 2'b00, 1'b1, 1'b1);
        step(10'h2AB); check_outs("tok_2ab", 8'h00, 2'b11, 1'b0, 1'b1);
        step(10'h0FF); check_outs("ctrl_hold", 8'hFF, 2'b11, 1'b1, 1'b1);
        step(10'h1FF); check_outs("dec_1ff", 8'h01, 2'b11, 1'b1, 1'b1);
        step(10'h2FF); check_outs("dec_2ff", 8'hFE, 2'b11, 1'b1, 1'b1);
        step(10'h355); check_outs("dec_355", 8'hFE, 2'b11, 1'b1, 1'b1);
        step(10'h0AB); check_outs("tok_0ab", 8'h00, 2'b01, 1'b0, 1'b1);
        step(10'h154); check_outs("tok_154", 8'h00, 2'b10, 1'b0, 1'b1);

        // Lock loss: falls after the 4095th token-free word.
        for (int i = 1; i <= 4095; i++) begin
            step(10'h100);
            if (i == 4094) check("loss_still_locked", 32'(locked), 32'd1);
        end
        check_outs("loss", 8'h00, 2'b00, 1'b0, 1'b0);
`ifdef TMDS_STATS_EN
        check("loss_count", 32'(loss_count), 32'd1);
        check("slip_count_after_loss", 32'(slip_count), 32'd0);
`endif

        // Misaligned stream: slips at 4096 and 4096+4112 after release.
        rst = 1'b1;
        step(10'h100);
        rst = 1'b0;
        first_slip  = 0;
        second_slip = 0;
        n_slips     = 0;
        lock_seen   = 0;
        for (int k = 1; k <= 8300; k++) begin
            step(10'h100);
            if (locked) lock_seen = 1;
            if (bitslip) begin
                n_slips++;
                if (first_slip == 0) first_slip = k;
                else if (second_slip == 0) second_slip = k;
            end
        end
        check("first_slip_cycle", 32'(first_slip), 32'd4096);
        check("second_slip_cycle", 32'(second_slip), 32'd8208);
        check("slip_pulses", 32'(n_slips), 32'd2);
        check("misaligned_never_locked", 32'(lock_seen), 32'd0);
`ifdef TMDS_STATS_EN
        check("slip_count", 32'(slip_count), 32'd2);
        check("loss_count_cleared", 32'(loss_count), 32'd0);
`endif

        // 8th token lands on window cycle 4095: lock wins, no slip.
        rst = 1'b1;
        step(10'h100);
        rst = 1'b0;
        slip_seen = 0;
        lock_seen = 0;
        for (int k = 1; k <= 4096; k++) begin
            step((k > 4088) ? 10'h354 : 10'h100);
            if (bitslip) slip_seen = 1;
            if (k < 4096 && locked) lock_seen = 1;
        end
        check("simul_early_lock", 32'(lock_seen), 32'd0);
        check("simul_locked", 32'(locked), 32'd1);
        check("simul_bitslip", 32'(bitslip), 32'd0);
        check("simul_no_slip", 32'(slip_seen), 32'd0);
        step(10'h100);
        check("simul_after_bitslip", 32'(bitslip), 32'd0);
        check_outs("simul_after", 8'h00, 2'b00, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
